// File: rtl/buraq_wb_arbiter.sv
// ---------------------------------------------------------------------------
// buraq_wb_arbiter
// Writeback arbiter for the single register-file write port. ALU results win
// the slot every cycle they are valid; long-latency (LSU/MDU) results queue in
// a small FIFO and drain whenever the ALU leaves the slot free. A pending-write
// scoreboard tracks long-latency destinations, and a starvation counter asks
// issue to hold off ALU results when the FIFO head has waited too long.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   alu_valid_i/waddr_i/wdata_i       single-cycle result (always accepted)
//   lsu_valid_i/ready_o/waddr_i/wdata_i  long-latency result handshake
//   issue_valid_i/issue_rd_i          long-latency op issued (sets busy bit)
//   busy_o                            scoreboard, bit r = write to xr pending
//   alu_stall_o                       request issue to withhold ALU results
//   rf_waddr_o/rf_wdata_o/rf_we_o     registered register-file write port
// ---------------------------------------------------------------------------
module buraq_wb_arbiter #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_valid_i,
  input  logic [4:0]           alu_waddr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  output logic [31:0]          busy_o,
  output logic                 alu_stall_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned StW  = $clog2(StarveLimit + 1);

  logic [4:0]           r_fifo_addr [FifoDepth];
  logic [DataWidth-1:0] r_fifo_data [FifoDepth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic [StW-1:0]       r_starve;
  logic                 r_stall;
  logic [31:0]          r_busy;
  logic                 r_rf_we;
  logic [4:0]           r_rf_waddr;
  logic [DataWidth-1:0] r_rf_wdata;

  logic                 w_empty;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic [4:0]           w_head_addr;
  logic [DataWidth-1:0] w_head_data;
  logic [CntW-1:0]      w_count_nxt;
  logic [StW-1:0]       w_starve_nxt;
  logic [31:0]          w_busy_nxt;

  assign w_empty     = (r_count == '0);
  assign w_ready     = (r_count < CntW'(FifoDepth));
  assign w_push      = lsu_valid_i & w_ready;
  // No bypass: only an entry already stored can pop, so push/pop never alias.
  assign w_pop       = ~alu_valid_i & ~w_empty;
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Ready reflects registered occupancy only; forced low while in reset.
  assign lsu_ready_o = w_ready & ~rst_i;
  assign busy_o      = r_busy;
  assign alu_stall_o = r_stall;
  assign rf_we_o     = r_rf_we;
  assign rf_waddr_o  = r_rf_waddr;
  assign rf_wdata_o  = r_rf_wdata;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CntW'(1);
      2'b01:   w_count_nxt = r_count - CntW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (r_starve != StW'(StarveLimit)) begin
      w_starve_nxt = r_starve + StW'(1);
    end
  end

  // Clear on pop first, then set on issue, so a same-register collision
  // leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) begin
      w_busy_nxt[w_head_addr] = 1'b0;
    end
    if (issue_valid_i) begin
      w_busy_nxt[issue_rd_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      r_fifo_addr[r_wr_ptr] <= lsu_waddr_i;
      r_fifo_data[r_wr_ptr] <= lsu_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_stall    <= 1'b0;
      r_busy     <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == StW'(StarveLimit));
      r_busy   <= w_busy_nxt;
      if (alu_valid_i) begin
        r_rf_we    <= (alu_waddr_i != 5'd0);
        r_rf_waddr <= alu_waddr_i;
        r_rf_wdata <= alu_wdata_i;
      end else if (w_pop) begin
        r_rf_we    <= (w_head_addr != 5'd0);
        r_rf_waddr <= w_head_addr;
        r_rf_wdata <= w_head_data;
      end else begin
        r_rf_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_buraq_wb_arbiter.sv
module tb_buraq_wb_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          alu_valid_i;
  logic [4:0]    alu_waddr_i;
  logic [DW-1:0] alu_wdata_i;
  logic          lsu_valid_i;
  logic          lsu_ready_o;
  logic [4:0]    lsu_waddr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic          issue_valid_i;
  logic [4:0]    issue_rd_i;
  logic [31:0]   busy_o;
  logic          alu_stall_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          rf_we_o;

  buraq_wb_arbiter #(
    .DataWidth  (DW),
    .FifoDepth  (DEPTH),
    .StarveLimit(LIMIT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alu_valid_i  (alu_valid_i),
    .alu_waddr_i  (alu_waddr_i),
    .alu_wdata_i  (alu_wdata_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_waddr_i  (lsu_waddr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .issue_valid_i(issue_valid_i),
    .issue_rd_i   (issue_rd_i),
    .busy_o       (busy_o),
    .alu_stall_o  (alu_stall_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .rf_we_o      (rf_we_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(alu_stall_o && alu_valid_i))
        else $error("protocol violation: ALU result presented while alu_stall_o high");
    end
  end

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: result queue, busy bit array, wait counter.
  typedef struct {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t          q[$];
  logic [31:0]   m_busy  = '0;
  int unsigned   m_wait  = 0;
  logic          m_we    = 1'b0;
  logic [4:0]    m_addr  = '0;
  logic [DW-1:0] m_data  = '0;
  logic          m_stall = 1'b0;

  task automatic model_step();
    ent_t e;
    int unsigned pre;
    bit popped;
    if (rst_i) begin
      q.delete();
      m_busy = '0; m_wait = 0; m_we = 0; m_addr = '0; m_data = '0; m_stall = 0;
      return;
    end
    pre = q.size();
    popped = 0;
    if (alu_valid_i) begin
      m_we = (alu_waddr_i != 0); m_addr = alu_waddr_i; m_data = alu_wdata_i;
    end else if (pre > 0) begin
      e = q.pop_front();
      popped = 1;
      m_we = (e.a != 0); m_addr = e.a; m_data = e.d;
      m_busy[e.a] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (lsu_valid_i && pre < DEPTH) begin
      e.a = lsu_waddr_i; e.d = lsu_wdata_i;
      q.push_back(e);
    end
    if (issue_valid_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
    if (pre > 0 && !popped) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
    else m_wait = 0;
    m_stall = (m_wait == LIMIT);
  endtask

  task automatic check_model();
    chk("m_we",    32'(rf_we_o),     32'(m_we));
    chk("m_addr",  32'(rf_waddr_o),  32'(m_addr));
    chk("m_data",  rf_wdata_o,       m_data);
    chk("m_busy",  busy_o,           m_busy);
    chk("m_stall", 32'(alu_stall_o), 32'(m_stall));
    chk("m_ready", 32'(lsu_ready_o), 32'(!rst_i && q.size() < DEPTH));
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    rst_i = 0; alu_valid_i = 0; alu_waddr_i = '0; alu_wdata_i = '0;
    lsu_valid_i = 0; lsu_waddr_i = '0; lsu_wdata_i = '0;
    issue_valid_i = 0; issue_rd_i = '0;
  endtask

  typedef struct {
    logic          rst;
    logic          av;
    logic [4:0]    aa;
    logic [DW-1:0] ad;
    logic          lv;
    logic [4:0]    la;
    logic [DW-1:0] ld;
    logic          iv;
    logic [4:0]    ir;
    logic          e_we;
    logic [4:0]    e_addr;
    logic [DW-1:0] e_data;
    logic          e_ready;
    logic [31:0]   e_busy;
    logic          e_stall;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]    wr_a[$];
    logic [DW-1:0] wr_d[$];
    int unsigned   k;
    int unsigned   n;
    logic [4:0]    bp_a[3];
    logic [DW-1:0] bp_d[3];
    bit            acc;

    //          rst av aa  ad            lv la  ld        iv ir  we addr data          rdy busy         stall
    tbl[0]  = '{1, 0, 0,  0,            1, 3,  32'hAA,   0, 0,  0, 0,   0,            0,  32'h0,       0};
    tbl[1]  = '{0, 0, 0,  0,            0, 0,  0,        0, 0,  0, 0,   0,            1,  32'h0,       0};
    tbl[2]  = '{0, 0, 0,  0,            0, 0,  0,        1, 7,  0, 0,   0,            1,  32'h80,      0};
    tbl[3]  = '{0, 1, 5,  32'hDEADBEEF, 0, 0,  0,        0, 0,  1, 5,   32'hDEADBEEF, 1,  32'h80,      0};
    tbl[4]  = '{0, 0, 0,  0,            1, 7,  32'h1234, 0, 0,  0, 5,   32'hDEADBEEF, 1,  32'h80,      0};
    tbl[5]  = '{0, 0, 0,  0,            0, 0,  0,        0, 0,  1, 7,   32'h1234,     1,  32'h0,       0};
    tbl[6]  = '{0, 0, 0,  0,            1, 0,  32'h55,   1, 9,  0, 7,   32'h1234,     1,  32'h200,     0};
    tbl[7]  = '{0, 0, 0,  0,            1, 9,  32'h99,   0, 0,  0, 0,   32'h55,       1,  32'h200,     0};
    tbl[8]  = '{0, 0, 0,  0,            0, 0,  0,        1, 9,  1, 9,   32'h99,       1,  32'h200,     0};
    tbl[9]  = '{0, 1, 0,  32'h77,       0, 0,  0,        1, 0,  0, 0,   32'h77,       1,  32'h200,     0};
    tbl[10] = '{0, 0, 0,  0,            0, 0,  0,        0, 0,  0, 0,   32'h77,       1,  32'h200,     0};

    idle_inputs();
    rst_i = 1;
    step();

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      rst_i = tbl[i].rst; alu_valid_i = tbl[i].av; alu_waddr_i = tbl[i].aa; alu_wdata_i = tbl[i].ad;
      lsu_valid_i = tbl[i].lv; lsu_waddr_i = tbl[i].la; lsu_wdata_i = tbl[i].ld;
      issue_valid_i = tbl[i].iv; issue_rd_i = tbl[i].ir;
      step();
      chk($sformatf("vec%0d_we", i),    32'(rf_we_o),     32'(tbl[i].e_we));
      chk($sformatf("vec%0d_addr", i),  32'(rf_waddr_o),  32'(tbl[i].e_addr));
      chk($sformatf("vec%0d_data", i),  rf_wdata_o,       tbl[i].e_data);
      chk($sformatf("vec%0d_ready", i), 32'(lsu_ready_o), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d_busy", i),  busy_o,           tbl[i].e_busy);
      chk($sformatf("vec%0d_stall", i), 32'(alu_stall_o), 32'(tbl[i].e_stall));
    end

    // Backpressure and starvation
    idle_inputs();
    bp_a[0] = 1; bp_a[1] = 2; bp_a[2] = 3;
    bp_d[0] = 32'h101; bp_d[1] = 32'h102; bp_d[2] = 32'h103;
    k = 0;
    alu_valid_i = 1; alu_waddr_i = 5'd20; alu_wdata_i = 32'hA000;
    lsu_valid_i = 1; lsu_waddr_i = bp_a[0]; lsu_wdata_i = bp_d[0];
    acc = lsu_ready_o;
    step();
    if (acc) k++;
    n = 0;
    while (n < 10 && !alu_stall_o) begin
      alu_wdata_i = 32'hA001 + n;
      lsu_valid_i = (k < 3);
      if (k < 3) begin lsu_waddr_i = bp_a[k]; lsu_wdata_i = bp_d[k]; end
      if (k == 2) chk("bp_ready_third", 32'(lsu_ready_o), 32'd0);
      acc = lsu_valid_i && lsu_ready_o;
      step();
      if (acc) k++;
      n++;
    end
    chk("bp_stall_wait", n, LIMIT);
    chk("bp_accepted", k, 2);
    alu_valid_i = 0;
    for (int s = 0; s < 6; s++) begin
      lsu_valid_i = (k < 3);
      if (k < 3) begin lsu_waddr_i = bp_a[k]; lsu_wdata_i = bp_d[k]; end
      acc = lsu_valid_i && lsu_ready_o;
      step();
      if (acc) k++;
      if (s == 0) begin
        chk("bp_ready_after_pop", 32'(lsu_ready_o), 32'd1);
        chk("bp_stall_clear", 32'(alu_stall_o), 32'd0);
      end
      if (rf_we_o) begin wr_a.push_back(rf_waddr_o); wr_d.push_back(rf_wdata_o); end
    end
    chk("bp_nwrites", wr_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_a.size()) begin
        chk($sformatf("bp_order_a%0d", i), 32'(wr_a[i]), 32'(bp_a[i]));
        chk($sformatf("bp_order_d%0d", i), wr_d[i], bp_d[i]);
      end
    end

    // Simultaneous push/pop at one entry; pointers wrap repeatedly
    idle_inputs();
    wr_d.delete();
    lsu_valid_i = 1; lsu_waddr_i = 5'd10; lsu_wdata_i = 32'hC000;
    step();
    for (int i = 1; i <= 8; i++) begin
      lsu_waddr_i = 5'(10 + i); lsu_wdata_i = 32'hC000 + i;
      chk($sformatf("wrap_ready%0d", i), 32'(lsu_ready_o), 32'd1);
      step();
      if (rf_we_o) wr_d.push_back(rf_wdata_o);
    end
    lsu_valid_i = 0;
    step();
    if (rf_we_o) wr_d.push_back(rf_wdata_o);
    chk("wrap_nwrites", wr_d.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < wr_d.size()) chk($sformatf("wrap_d%0d", i), wr_d[i], 32'hC000 + i);
    end

    // Reset mid-operation with two buffered entries
    idle_inputs();
    alu_valid_i = 1; alu_waddr_i = 5'd4; alu_wdata_i = 32'hB0;
    lsu_valid_i = 1; lsu_waddr_i = 5'd12; lsu_wdata_i = 32'hE1;
    issue_valid_i = 1; issue_rd_i = 5'd12;
    step();
    lsu_waddr_i = 5'd13; lsu_wdata_i = 32'hE2; issue_rd_i = 5'd13;
    step();
    chk("rst_pre_full", 32'(lsu_ready_o), 32'd0);
    rst_i = 1; alu_valid_i = 0; issue_valid_i = 0; lsu_waddr_i = 5'd14; lsu_wdata_i = 32'hE3;
    step();
    chk("rst_busy", busy_o, 32'd0);
    chk("rst_we", 32'(rf_we_o), 32'd0);
    idle_inputs();
    #1;
    chk("rst_release_ready", 32'(lsu_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rst_no_stale%0d", i), 32'(rf_we_o), 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_i         = ($urandom_range(63) == 0);
      alu_valid_i   = !alu_stall_o && ($urandom_range(99) < 45);
      alu_waddr_i   = 5'($urandom_range(31));
      alu_wdata_i   = $urandom;
      lsu_valid_i   = ($urandom_range(99) < 50);
      lsu_waddr_i   = 5'($urandom_range(31));
      lsu_wdata_i   = $urandom;
      issue_valid_i = ($urandom_range(99) < 30);
      issue_rd_i    = 5'($urandom_range(31));
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/buraq_wb_arbiter.md
Name: buraq_wb_arbiter

Overview:
Writeback stage that feeds the single register-file write port. Merges two result sources onto one registered write port:
- single-cycle ALU results, which always take priority;
- long-latency LSU/MDU results, buffered in a small FIFO behind a valid/ready handshake.
Also keeps a pending-write scoreboard of destination registers for the hazard unit, and raises a stall request toward issue when buffered results starve.

Parameters:
DataWidth, 32, width of write data.
FifoDepth, 2, number of entries in the long-latency result FIFO (power of two, >=2).
StarveLimit, 4, consecutive cycles the FIFO head may wait before alu_stall_o asserts.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset
alu_valid_i  input  1  ALU result valid this cycle (no ready; always accepted)
alu_waddr_i  input  5  ALU destination register
alu_wdata_i  input  DataWidth  ALU result
lsu_valid_i  input  1  long-latency result valid
lsu_ready_o  output  1  FIFO can accept a long-latency result
lsu_waddr_i  input  5  long-latency destination register
lsu_wdata_i  input  DataWidth  long-latency result
issue_valid_i  input  1  long-latency op issued this cycle
issue_rd_i  input  5  destination of issued long-latency op
busy_o  output  32  scoreboard; bit r set = write to xr pending
alu_stall_o  output  1  request issue to withhold ALU results next cycle
rf_waddr_o  output  5  register-file write address
rf_wdata_o  output  DataWidth  register-file write data
rf_we_o  output  1  register-file write enable

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values while rst_i high:
  - all outputs 0, including lsu_ready_o;
  - FIFO empty, occupancy count 0;
  - busy_o = 0;
  - starvation counter 0.
  - Data accepted in the reset cycle is discarded.
  - From the first cycle after rst_i deasserts, lsu_ready_o = 1.
- Write port: rf_waddr_o, rf_wdata_o and rf_we_o are registered.
  - A slot selected in cycle N appears in cycle N+1.
  - With no selection, rf_we_o = 0 and addr/data hold their previous values.
- Slot priority:
  - alu_valid_i=1 wins the slot unconditionally.
  - Otherwise a non-empty FIFO pops its head into the slot.
  - Exactly one write per cycle at most.
- Handshake:
  - lsu_ready_o = (count < FifoDepth). It is based on registered state only and does not depend on a same-cycle pop.
  - Push happens when lsu_valid_i & lsu_ready_o.
  - Push and pop in the same cycle leaves count unchanged.
  - There is no bypass: minimum LSU latency is accept in N, pop in N+1, rf_we_o in N+2.
  - FIFO order is strictly preserved; wrap-around pointers are sized log2(FifoDepth).
- x0 handling:
  - An ALU write to x0 still consumes the slot but drives rf_we_o = 0.
  - A FIFO entry to x0 pops normally with rf_we_o = 0.
  - busy_o[0] is constant 0, and issue_rd_i = 0 is ignored.
- Scoreboard:
  - issue_valid_i sets busy[issue_rd_i] at the next edge.
  - A FIFO pop clears busy[popped addr] at the same edge the slot is loaded.
  - ALU writes never touch busy.
  - If set and clear hit the same register in the same cycle, set wins.
- Starvation counter (saturating at StarveLimit):
  - increments each cycle the FIFO is non-empty and not popped;
  - clears on a pop or when the FIFO is empty.
  - alu_stall_o is registered and is 1 while counter == StarveLimit.
  - The cycle after alu_stall_o rises, issue must drop alu_valid_i, so the head pops and the counter clears.
  - If alu_valid_i is still asserted, the ALU still wins (protocol violation, flagged by a bench assertion).
- The block does not reorder or check WAW hazards; upstream guarantees an ALU write never targets a busy register.
- Reset mid-operation discards FIFO contents, busy bits and any pending write; rf_we_o is 0 the cycle after rst_i is sampled high.

Test Plan:
- ALU alone: alu_valid_i=1, waddr=5, wdata=0xDEADBEEF in cycle 10 -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF in cycle 11; busy_o unchanged.
- LSU latency and scoreboard: issue rd=7 in cycle 3 -> busy_o[7]=1 from cycle 4. LSU result (7, 0x1234) accepted in cycle 8 -> rf_we_o in cycle 10, busy_o[7]=0 from cycle 10.
- Backpressure: ALU valid every cycle while 3 LSU results are offered back-to-back -> first 2 accepted, lsu_ready_o=0 on the third. alu_stall_o rises after 4 waiting cycles. ALU drops the next cycle -> head pops and lsu_ready_o returns to 1. Write order matches acceptance order.
- Simultaneous push/pop with FIFO at 1 entry -> count stays 1, lsu_ready_o stays 1; 8 sequential results wrap the pointers with data intact.
- x0 and set-wins: LSU result to x0 -> pop occurs, rf_we_o=0. Issue rd=9 in the same cycle a pop clears x9 -> busy_o[9]=1.
- Reset mid-operation: FIFO holds 2 entries, rst_i high for 1 cycle -> busy_o=0, rf_we_o=0, no stale writes afterwards, lsu_ready_o=1 the cycle after release.
